pwm_breath: RTL and testbench
=============================

PWM_BREATH -- requirements
Module: pwm_breath

Interface
REQ-001 Parameter DUTY_W, default 8, SHALL set the duty output width and the min/max input width.
REQ-002 Parameter DIV_W, default 16, SHALL set the prescaler width.
REQ-003 Parameter HOLD_W, default 8, SHALL set the hold-count width.
REQ-004 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 en  in  1  SHALL be the level enable; high runs the breathing sequence, low forces IDLE.
REQ-007 step_div  in  DIV_W  SHALL be the clocks per duty step; 0 is treated as 1.
REQ-008 min_duty  in  DUTY_W  SHALL be the trough duty value.
REQ-009 max_duty  in  DUTY_W  SHALL be the peak duty value.
REQ-010 hold_steps  in  HOLD_W  SHALL be the extra ticks of dwell at peak and at trough.
REQ-011 duty  out  DUTY_W  SHALL be the registered duty word that feeds the downstream PWM generator's duty input.
REQ-012 duty_upd  out  1  SHALL be a registered pulse, high for the one cycle after any cycle in which duty changed value.
REQ-013 cycle_done  out  1  SHALL be a registered one-cycle pulse marking completion of a full trough-to-trough cycle.
REQ-014 state  out  3  SHALL be the current FSM state: IDLE=0, RISE=1, HOLD_HI=2, FALL=3, HOLD_LO=4.

Function
REQ-015 Config capture: step_div, min_duty, max_duty and hold_steps SHALL be sampled into shadow registers only on the IDLE->run transition and on HOLD_LO exit. Input changes at other times SHALL have no effect.
REQ-016 Prescaler: a down-counter SHALL load div_s-1 on each capture, where div_s = max(step_div,1).
REQ-017 In non-IDLE states, when the prescaler is 0, tick SHALL be asserted and the counter reloaded to div_s-1; otherwise the counter SHALL decrement. Tick period SHALL be exactly div_s clocks.
REQ-018 IDLE with en=1: duty <= min_s. Next state SHALL be HOLD_LO if min_s >= max_s, else RISE.
REQ-019 RISE on tick: duty <= duty+1. When duty+1 == max_s, the FSM SHALL move to HOLD_HI.
REQ-020 FALL on tick: duty <= duty-1. When duty-1 == min_s, the FSM SHALL move to HOLD_LO.
REQ-021 HOLD_HI/HOLD_LO: hold_cnt SHALL clear on entry and increment on each tick. The state SHALL exit on the tick where hold_cnt == hold_s, so dwell is hold_s+1 ticks.
REQ-022 HOLD_HI exit SHALL go to FALL.
REQ-023 HOLD_LO exit SHALL perform, in the same edge: pulse cycle_done, recapture config, and set duty <= new min_s. Next state SHALL be RISE, or HOLD_LO again if new min_s >= new max_s.
REQ-024 When min_s >= max_s, duty SHALL stay constant at min_s, and cycle_done SHALL still pulse on each HOLD_LO exit.
REQ-025 Duty arithmetic SHALL never wrap: duty SHALL remain within [min_s, max_s] whenever min_s < max_s.
REQ-026 en=0 in any state SHALL cause, at the next edge: state <= IDLE, duty <= 0, prescaler and hold_cnt <= 0, and no cycle_done.
REQ-027 Re-assertion of en after en=0 SHALL restart per REQ-018, with no memory of the prior phase.
REQ-028 When a tick and an en falling edge coincide, en=0 SHALL take priority.
REQ-029 Each tick in RISE or FALL SHALL change duty by exactly 1.

Reset
REQ-030 rst_n=0 SHALL asynchronously force: state=IDLE, duty=0, duty_upd=0, cycle_done=0, prescaler=0, hold_cnt=0, all shadow registers=0.
REQ-031 Release of rst_n SHALL take effect at the first clk edge with rst_n=1. Reset asserted mid-sequence SHALL discard all progress.

Verification
REQ-032 Basic cycle: step_div=1, min=2, max=5, hold=0, en=1 -> duty per edge: 2,3,4,5,5,4,3,2,2,3…; cycle_done every 8 clocks; state trace 1,1,1,2,3,3,3,4,1.
REQ-033 Prescale and hold: step_div=4, min=0, max=2, hold=1 -> each duty step lasts 4 clocks; peak dwell is 8 clocks; duty_upd fires only on value changes.
REQ-034 Degenerate config: min=7, max=7, step_div=0 -> duty constant at 7, state=HOLD_LO, cycle_done every 1 clock (hold=0).
REQ-035 Mid-run reconfig: change max from 5 to 9 during FALL -> current cycle still peaks at 5; next cycle peaks at 9; the new value takes effect only at HOLD_LO exit.
REQ-036 Abort: drop en during RISE at duty=4 -> next edge duty=0, state=IDLE. Re-raise en -> duty=min, state=RISE.
REQ-037 Async reset: pulse rst_n low between edges during HOLD_HI -> outputs clear immediately without waiting for a clock edge, and the sequence restarts from IDLE after release.

Source files
------------

// File: rtl/pwm_breath_if.sv
// pwm_breath_if: run/config inputs and duty/status outputs of the breathing duty sequencer
interface pwm_breath_if #(
  parameter int DUTY_W = 8,
  parameter int DIV_W  = 16,
  parameter int HOLD_W = 8
);
  logic              en;
  logic [DIV_W-1:0]  step_div;
  logic [DUTY_W-1:0] min_duty;
  logic [DUTY_W-1:0] max_duty;
  logic [HOLD_W-1:0] hold_steps;
  logic [DUTY_W-1:0] duty;
  logic              duty_upd;
  logic              cycle_done;
  logic [2:0]        state;
  modport master (
    output en, step_div, min_duty, max_duty, hold_steps,
    input  duty, duty_upd, cycle_done, state
  );
  modport slave (
    input  en, step_div, min_duty, max_duty, hold_steps,
    output duty, duty_upd, cycle_done, state
  );
endinterface

// File: rtl/pwm_breath.sv
// pwm_breath: ramps a duty word between min and max one step per prescaled tick, dwelling at each end
module pwm_breath #(
  parameter int DUTY_W = 8,
  parameter int DIV_W  = 16,
  parameter int HOLD_W = 8
) (
  input logic         clk,
  input logic         rst_n,
  pwm_breath_if.slave bus
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RISE    = 3'd1;
  localparam logic [2:0] HOLD_HI = 3'd2;
  localparam logic [2:0] FALL    = 3'd3;
  localparam logic [2:0] HOLD_LO = 3'd4;
  logic [2:0]        r_state, w_state;
  logic [DUTY_W-1:0] r_duty, w_duty, r_min, r_max, w_up, w_dn;
  logic [DIV_W-1:0]  r_div, r_pre, w_pre, w_div_in;
  logic [HOLD_W-1:0] r_hold_s, r_hold, w_hold;
  logic              r_upd, r_done, w_done, w_cap, w_tick, w_hold_end;
  assign w_div_in   = (bus.step_div == '0) ? DIV_W'(1) : bus.step_div;
  assign w_tick     = (r_pre == '0);
  assign w_hold_end = w_tick && (r_hold == r_hold_s);
  assign w_up       = r_duty + DUTY_W'(1);
  assign w_dn       = r_duty - DUTY_W'(1);
  // config is only sampled when a new trough-to-trough cycle starts
  assign w_cap      = bus.en && (r_state == IDLE || (r_state == HOLD_LO && w_hold_end));
  always_comb begin
    w_state = r_state;
    w_duty  = r_duty;
    w_hold  = r_hold;
    w_done  = 1'b0;
    w_pre   = w_tick ? r_div - DIV_W'(1) : r_pre - DIV_W'(1);
    if (!bus.en) begin
      w_state = IDLE;
      w_duty  = '0;
      w_pre   = '0;
      w_hold  = '0;
    end else if (w_cap) begin
      w_state = (bus.min_duty >= bus.max_duty) ? HOLD_LO : RISE;
      w_duty  = bus.min_duty;
      w_pre   = w_div_in - DIV_W'(1);
      w_hold  = '0;
      w_done  = (r_state == HOLD_LO);
    end else if (w_tick) begin
      if (r_state == RISE) begin
        w_duty  = w_up;
        w_state = (w_up == r_max) ? HOLD_HI : RISE;
      end else if (r_state == FALL) begin
        w_duty  = w_dn;
        w_state = (w_dn == r_min) ? HOLD_LO : FALL;
      end else if (r_state == HOLD_HI || r_state == HOLD_LO) begin
        w_hold  = w_hold_end ? '0 : r_hold + HOLD_W'(1);
        w_state = (w_hold_end && r_state == HOLD_HI) ? FALL : r_state;
      end else begin
        w_state = IDLE;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_duty   <= '0;
      r_upd    <= 1'b0;
      r_done   <= 1'b0;
      r_pre    <= '0;
      r_hold   <= '0;
      r_div    <= '0;
      r_min    <= '0;
      r_max    <= '0;
      r_hold_s <= '0;
    end else begin
      r_state <= w_state;
      r_duty  <= w_duty;
      r_upd   <= (w_duty != r_duty);
      r_done  <= w_done;
      r_pre   <= w_pre;
      r_hold  <= w_hold;
      if (w_cap) begin
        r_div    <= w_div_in;
        r_min    <= bus.min_duty;
        r_max    <= bus.max_duty;
        r_hold_s <= bus.hold_steps;
      end
    end
  end
  assign bus.duty       = r_duty;
  assign bus.duty_upd   = r_upd;
  assign bus.cycle_done = r_done;
  assign bus.state      = r_state;
endmodule

// File: tb/tb_pwm_breath.sv
// tb_pwm_breath: vector table, directed corner sequences and a random run against a cycle-plan model
module tb_pwm_breath;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  pwm_breath_if #(.DUTY_W(8), .DIV_W(16), .HOLD_W(8)) bus ();
  pwm_breath #(.DUTY_W(8), .DIV_W(16), .HOLD_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {bit en; int dv; int mn; int mx; int h; int d; int s; int c; int u;} vec_t;
  typedef struct {int d; int s; int c;} ev_t;
  vec_t tab[14];
  ev_t q[$];
  ev_t ex;
  int ex_u, prev_d, in_run;
  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic cfg(input bit en, input int dv, input int mn, input int mx, input int h);
    bus.en = en;
    bus.step_div = 16'(dv);
    bus.min_duty = 8'(mn);
    bus.max_duty = 8'(mx);
    bus.hold_steps = 8'(h);
  endtask
  task automatic wait_state(input int s, input string nm);
    int ok = 0;
    for (int i = 0; i < 200 && ok == 0; i++) begin
      if (int'(bus.state) == s) ok = 1;
      else cyc();
    end
    check(nm, ok, 1);
  endtask
  task automatic push(input int v, input int s, input int n);
    for (int i = 0; i < n; i++) q.push_back('{v, s, 0});
  endtask
  // whole trough-to-trough plan: the capture edge, then every following edge up to the next capture
  task automatic build(input int d, input int mn, input int mx, input int h, input int done);
    int dv = (d == 0) ? 1 : d;
    int cur = mn;
    q.push_back('{mn, (mn >= mx) ? 4 : 1, done});
    if (mn < mx) begin
      for (int v = mn + 1; v <= mx; v++) begin
        push(cur, 1, dv - 1);
        q.push_back('{v, (v == mx) ? 2 : 1, 0});
        cur = v;
      end
      for (int k = 0; k <= h; k++) begin
        push(mx, 2, dv - 1);
        q.push_back('{mx, (k == h) ? 3 : 2, 0});
      end
      for (int v = mx - 1; v >= mn; v--) begin
        push(cur, 3, dv - 1);
        q.push_back('{v, (v == mn) ? 4 : 3, 0});
        cur = v;
      end
    end
    for (int k = 0; k <= h; k++) begin
      push(mn, 4, dv - 1);
      if (k < h) q.push_back('{mn, 4, 0});
    end
  endtask
  task automatic model_step();
    if (!bus.en) begin
      q.delete();
      ex = '{0, 0, 0};
      in_run = 0;
    end else begin
      if (q.size() == 0) build(int'(bus.step_div), int'(bus.min_duty), int'(bus.max_duty), int'(bus.hold_steps), in_run);
      ex = q.pop_front();
      in_run = 1;
    end
    ex_u = (ex.d != prev_d) ? 1 : 0;
    prev_d = ex.d;
  endtask
  initial begin
    int peak, n, hh, ones, ups;
    cfg(0, 0, 0, 0, 0);
    tab[0]  = '{1, 1, 2, 5, 0, 2, 1, 0, 1};
    tab[1]  = '{1, 1, 2, 5, 0, 3, 1, 0, 1};
    tab[2]  = '{1, 1, 2, 5, 0, 4, 1, 0, 1};
    tab[3]  = '{1, 1, 2, 5, 0, 5, 2, 0, 1};
    tab[4]  = '{1, 1, 2, 5, 0, 5, 3, 0, 0};
    tab[5]  = '{1, 1, 2, 5, 0, 4, 3, 0, 1};
    tab[6]  = '{1, 1, 2, 5, 0, 3, 3, 0, 1};
    tab[7]  = '{1, 1, 2, 5, 0, 2, 4, 0, 1};
    tab[8]  = '{1, 1, 2, 5, 0, 2, 1, 1, 0};
    tab[9]  = '{1, 1, 2, 5, 0, 3, 1, 0, 1};
    tab[10] = '{1, 1, 2, 5, 0, 4, 1, 0, 1};
    tab[11] = '{0, 1, 2, 5, 0, 0, 0, 0, 1};
    tab[12] = '{1, 1, 2, 5, 0, 2, 1, 0, 1};
    tab[13] = '{1, 1, 2, 5, 0, 3, 1, 0, 1};
    cyc();
    check("rst_duty", int'(bus.duty), 0);
    check("rst_state", int'(bus.state), 0);
    check("rst_done", int'(bus.cycle_done), 0);
    check("rst_upd", int'(bus.duty_upd), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      cfg(tab[i].en, tab[i].dv, tab[i].mn, tab[i].mx, tab[i].h);
      cyc();
      check($sformatf("vec%0d_duty", i), int'(bus.duty), tab[i].d);
      check($sformatf("vec%0d_state", i), int'(bus.state), tab[i].s);
      check($sformatf("vec%0d_done", i), int'(bus.cycle_done), tab[i].c);
      check($sformatf("vec%0d_upd", i), int'(bus.duty_upd), tab[i].u);
    end
    cfg(0, 0, 7, 7, 0);
    cyc();
    bus.en = 1'b1;
    cyc();
    check("degen_duty0", int'(bus.duty), 7);
    check("degen_state0", int'(bus.state), 4);
    check("degen_done0", int'(bus.cycle_done), 0);
    check("degen_upd0", int'(bus.duty_upd), 1);
    for (int i = 1; i <= 3; i++) begin
      cyc();
      check($sformatf("degen_done%0d", i), int'(bus.cycle_done), 1);
      check($sformatf("degen_duty%0d", i), int'(bus.duty), 7);
      check($sformatf("degen_state%0d", i), int'(bus.state), 4);
      check($sformatf("degen_upd%0d", i), int'(bus.duty_upd), 0);
    end
    cfg(0, 4, 0, 2, 1);
    cyc();
    bus.en = 1'b1;
    cyc();
    n = 0; hh = 0; ones = 0; ups = 0;
    do begin
      cyc();
      n++;
      hh += (bus.state == 3'd2) ? 1 : 0;
      ones += (bus.duty == 8'd1) ? 1 : 0;
      ups += int'(bus.duty_upd);
    end while (!bus.cycle_done && n < 200);
    check("pre_period", n, 32);
    check("pre_peak_dwell", hh, 8);
    check("pre_step_len", ones, 8);
    check("pre_upd_count", ups, 4);
    cfg(0, 1, 2, 5, 0);
    cyc();
    bus.en = 1'b1;
    peak = 0; n = 0;
    do begin
      cyc();
      n++;
      if (int'(bus.duty) > peak) peak = int'(bus.duty);
      if (bus.state == 3'd3) bus.max_duty = 8'd9;
    end while (!bus.cycle_done && n < 100);
    check("reconf_peak1", peak, 5);
    bus.max_duty = 8'd5;
    peak = 0; n = 0;
    do begin
      cyc();
      n++;
      if (int'(bus.duty) > peak) peak = int'(bus.duty);
    end while (!bus.cycle_done && n < 100);
    check("reconf_peak2", peak, 9);
    cfg(0, 1, 1, 4, 3);
    cyc();
    bus.en = 1'b1;
    wait_state(2, "arst_reach_hold_hi");
    #2 rst_n = 1'b0;
    #1;
    check("arst_duty", int'(bus.duty), 0);
    check("arst_state", int'(bus.state), 0);
    check("arst_done", int'(bus.cycle_done), 0);
    check("arst_upd", int'(bus.duty_upd), 0);
    rst_n = 1'b1;
    cyc();
    check("arst_restart_state", int'(bus.state), 1);
    check("arst_restart_duty", int'(bus.duty), 1);
    bus.en = 1'b0;
    cyc();
    cyc();
    q.delete();
    in_run = 0;
    prev_d = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: bus.step_div = 16'($urandom_range(0, 3));
          1: bus.min_duty = 8'($urandom_range(0, 15));
          2: bus.max_duty = 8'($urandom_range(0, 15));
          default: bus.hold_steps = 8'($urandom_range(0, 3));
        endcase
      end
      bus.en = ($urandom_range(0, 149) != 0);
      @(posedge clk);
      model_step();
      #1;
      check("rnd_duty", int'(bus.duty), ex.d);
      check("rnd_state", int'(bus.state), ex.s);
      check("rnd_done", int'(bus.cycle_done), ex.c);
      check("rnd_upd", int'(bus.duty_upd), ex_u);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
